// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: a circular buffer that accepts whole fetch beats
// and delivers one registered instruction per cycle to decode.
module prefetch_queue #(
  parameter int unsigned INST_W  = 16,
  parameter int unsigned FETCH_N = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FETCH_N*INST_W-1:0]   fetch_data,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic                        stall_flg,
  input  logic                        flush,
  output logic [INST_W-1:0]           inst,
  output logic                        inst_valid,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [INST_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;

  logic space_ok;
  logic push;
  logic pop;

  // Room for a complete beat; forced high while reset is held.
  assign space_ok    = (CW'(DEPTH) - count_q) >= CW'(FETCH_N);
  assign fetch_ready = rst | space_ok;

  assign push = ~rst & fetch_valid & space_ok & ~flush;
  assign pop  = ~rst & ~stall_flg & ~flush & (count_q != '0);

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;

    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      inst_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(FETCH_N);
      end
      if (pop) begin
        inst_d       = mem_q[rd_ptr_q];
        inst_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PW'(1);
      end else if (!stall_flg) begin
        // Decode consumed the last instruction and nothing is queued behind it.
        inst_valid_d = 1'b0;
      end
      count_d = count_q + (push ? CW'(FETCH_N) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Storage has no reset; slice 0 of a beat lands at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < FETCH_N; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= fetch_data[i*INST_W +: INST_W];
      end
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign count      = count_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_prefetch_queue;

  localparam int unsigned INST_W  = 16;
  localparam int unsigned FETCH_N = 2;
  localparam int unsigned DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        stall_flg;
  logic        flush;
  logic [15:0] inst;
  logic        inst_valid;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  prefetch_queue #(.INST_W(INST_W), .FETCH_N(FETCH_N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .stall_flg   (stall_flg),
    .flush       (flush),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: a plain FIFO of instructions plus the output register.
  logic [15:0] mq[$];
  logic [15:0] m_inst;
  logic        m_valid;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_inst   = '0;
      m_valid  = 1'b0;
      model_ok = 1;
    end else if (flush) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      bit room;
      room = (DEPTH - mq.size()) >= FETCH_N;
      if (!stall_flg) begin
        if (mq.size() > 0) begin
          m_inst  = mq.pop_front();
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (fetch_valid && room) begin
        for (int i = 0; i < FETCH_N; i++) mq.push_back(fetch_data[i*INST_W +: INST_W]);
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_inst_valid", 32'(inst_valid), 32'(m_valid));
      chk("cyc_inst", 32'(inst), 32'(m_inst));
      chk("cyc_count", 32'(count), 32'(mq.size()));
      chk("cyc_fetch_ready", 32'(fetch_ready),
          32'(rst ? 1 : ((DEPTH - mq.size()) >= FETCH_N)));
    end
  end

  logic [15:0] got[$];

  // Advance one edge; log inst whenever a pop was due on that edge.
  task automatic tick();
    int  pc;
    bit  ps, pf, pr;
    pc = int'(count);
    ps = stall_flg;
    pf = flush;
    pr = rst;
    @(posedge clk);
    #1;
    if (!pr && !pf && !ps && pc != 0) got.push_back(inst);
  endtask

  initial begin
    int n;
    rst = 1'b1; fetch_data = '0; fetch_valid = 1'b0; stall_flg = 1'b0; flush = 1'b0;
    tick();
    chk("rst_inst", 32'(inst), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready_held", 32'(fetch_ready), 32'h1);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(fetch_ready), 32'h1);

    // Basic order
    fetch_data = 32'h2222_1111; fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    chk("basic_e1_count", 32'(count), 32'h2);
    tick();
    chk("basic_e2_inst", 32'(inst), 32'h1111);
    chk("basic_e2_valid", 32'(inst_valid), 32'h1);
    tick();
    chk("basic_e3_inst", 32'(inst), 32'h2222);
    tick();
    chk("basic_e4_valid", 32'(inst_valid), 32'h0);
    chk("basic_e4_inst", 32'(inst), 32'h2222);

    // Full queue under stall
    stall_flg = 1'b1; fetch_valid = 1'b1; fetch_data = 32'hB0B0_A0A0;
    tick();
    fetch_data = 32'hD0D0_C0C0;
    tick();
    chk("full_count", 32'(count), 32'h4);
    chk("full_ready", 32'(fetch_ready), 32'h0);
    fetch_data = 32'hF0F0_E0E0;
    tick();
    chk("full_ignored_count", 32'(count), 32'h4);
    fetch_valid = 1'b0; stall_flg = 1'b0;
    tick(); chk("full_out0", 32'(inst), 32'hA0A0);
    tick(); chk("full_out1", 32'(inst), 32'hB0B0);
    tick(); chk("full_out2", 32'(inst), 32'hC0C0);
    tick(); chk("full_out3", 32'(inst), 32'hD0D0);

    // Simultaneous push and pop with count=2, inst_valid=1
    stall_flg = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h8888_7777;
    tick();
    chk("pp_pre_count", 32'(count), 32'h2);
    chk("pp_pre_valid", 32'(inst_valid), 32'h1);
    stall_flg = 1'b0; fetch_data = 32'h4444_3333;
    tick();
    fetch_valid = 1'b0;
    chk("pp_count", 32'(count), 32'h3);
    chk("pp_inst", 32'(inst), 32'h7777);

    // Flush beats stall and fetch
    stall_flg = 1'b1; flush = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h6666_5555;
    tick();
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(inst_valid), 32'h0);
    chk("flush_inst", 32'(inst), 32'h7777);
    chk("flush_ready", 32'(fetch_ready), 32'h1);
    flush = 1'b0; fetch_valid = 1'b0; stall_flg = 1'b0;
    tick(); tick();
    chk("flush_no5555", 32'(inst), 32'h7777);
    chk("flush_still_empty", 32'(inst_valid), 32'h0);

    // Wrap-around with interleaved pops
    got.delete();
    for (int b = 0; b < 6; b++) begin
      fetch_data = {16'(2*b + 2), 16'(2*b + 1)};
      fetch_valid = 1'b1;
      n = 0;
      while (!fetch_ready && n < 20) begin tick(); n++; end
      if (n >= 20) chk("wrap_ready_timeout", 32'(fetch_ready), 32'h1);
      tick();
    end
    fetch_valid = 1'b0;
    n = 0;
    while (got.size() < 12 && n < 40) begin tick(); n++; end
    chk("wrap_len", 32'(got.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk("wrap_seq", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(i + 1));

    // Reset wins over everything with a full queue
    stall_flg = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h1212_3434;
    tick(); tick();
    chk("rp_pre_count", 32'(count), 32'h4);
    rst = 1'b1; flush = 1'b1;
    tick();
    chk("rp_inst", 32'(inst), 32'h0);
    chk("rp_valid", 32'(inst_valid), 32'h0);
    chk("rp_count", 32'(count), 32'h0);
    chk("rp_ready", 32'(fetch_ready), 32'h1);
    rst = 1'b0; flush = 1'b0; fetch_valid = 1'b0; stall_flg = 1'b0;
    tick();
    chk("rp_ready_after", 32'(fetch_ready), 32'h1);
    chk("rp_count_after", 32'(count), 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL have these parameters:
- INST_W, default 16: instruction width in bits.
- FETCH_N, default 2: instructions delivered per fetch beat.
- DEPTH, default 4: queue entries; power of two and at least FETCH_N.

REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- fetch_data  in  FETCH_N*INST_W  fetch beat; slice i is bits [i*INST_W +: INST_W], and slice 0 is the oldest instruction.
- fetch_valid  in  1  fetch_data is valid this cycle.
- fetch_ready  out  1  queue can accept one full beat.
- stall_flg  in  1  pipeline stall; holds the output stage.
- flush  in  1  discard all queued instructions and the output.
- inst  out  INST_W  registered instruction to decode.
- inst_valid  out  1  inst holds a live instruction.
- count  out  $clog2(DEPTH)+1  entries currently queued, excluding inst.

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries, INST_W bits each, with read and write pointers that wrap modulo DEPTH.

REQ-004 fetch_ready SHALL be combinational: 1 exactly when (DEPTH - count) >= FETCH_N.

REQ-005 A push SHALL occur on a cycle where fetch_valid=1, fetch_ready=1 and flush=0.
- On a push, slices 0..FETCH_N-1 SHALL be written to consecutive entries starting at the write pointer.
- The write pointer SHALL then advance by FETCH_N.

REQ-006 fetch_valid while fetch_ready=0 SHALL be ignored; no state changes and no data is lost from the queue.

REQ-007 A pop SHALL occur on a cycle where stall_flg=0, flush=0 and count>0.
- On a pop, inst SHALL load the entry at the read pointer, inst_valid SHALL become 1, and the read pointer SHALL advance by 1.

REQ-008 With stall_flg=0, flush=0 and count=0, inst_valid SHALL become 0 and inst SHALL hold its value.

REQ-009 With stall_flg=1 and flush=0, inst and inst_valid SHALL hold. Pushes SHALL still be accepted during a stall.

REQ-010 A push and a pop in the same cycle SHALL both take effect; count SHALL change by FETCH_N-1.

REQ-011 There SHALL be no bypass. An instruction pushed at edge k SHALL reach inst no earlier than edge k+1, giving minimum fetch-to-inst latency of 2 edges.

REQ-012 Output order SHALL equal arrival order across beats and across pointer wrap-around.

REQ-013 flush=1 SHALL override stall_flg and fetch_valid. On the next edge: count=0, pointers equal, inst_valid=0, inst holds its value, and any same-cycle fetch beat is discarded.

REQ-014 count SHALL never exceed DEPTH, and no pop SHALL occur with count=0.

Reset
REQ-015 rst=1 at a rising edge SHALL override all other inputs and set inst=0, inst_valid=0, count=0, and both pointers to 0. Queue contents need not be cleared.

REQ-016 While rst=1, and on the first cycle after rst deasserts, fetch_ready SHALL read 1.

REQ-017 Reset asserted mid-operation, including during a stall, full queue or flush, SHALL produce the state given in REQ-015 on the same edge.

Verification (INST_W=16, FETCH_N=2, DEPTH=4)
REQ-018 Basic order: after reset, one beat with fetch_data=0x2222_1111 and stall_flg=0. Required response:
- Edge +1: count=2.
- Edge +2: inst=0x1111, inst_valid=1.
- Edge +3: inst=0x2222.
- Edge +4: inst_valid=0, inst=0x2222.

REQ-019 Full queue: stall_flg=1, with beats 0xB0B0_A0A0 then 0xD0D0_C0C0 and fetch_valid held high. Required response:
- count=4 and fetch_ready=0.
- A third beat 0xF0F0_E0E0 is ignored.
- On release of stall_flg, the output sequence is A0A0, B0B0, C0C0, D0D0.

REQ-020 Simultaneous push/pop: with count=2 and inst_valid=1, push 0x4444_3333 with stall_flg=0. Required response: count=3 after the edge, and inst equals the previous head.

REQ-021 Flush precedence: with count=3 and stall_flg=1, assert flush together with fetch_valid (0x6666_5555). Required response:
- Next edge: count=0, inst_valid=0, inst unchanged, fetch_ready=1.
- 0x5555 never appears at inst.

REQ-022 Wrap-around: six consecutive beats 0x0002_0001 through 0x000C_000B, with pops interleaved. Required response: inst sequence 0x0001..0x000C with no gaps or duplicates.

REQ-023 Reset priority: assert rst with stall_flg=1, flush=1, fetch_valid=1 and count=4. Required response: next edge inst=0, inst_valid=0, count=0, fetch_ready=1.
